// File: rtl/btn_debounce_repeat.sv
// Push-button conditioner: 2-FF synchroniser, tick-sampled debounce, one-clk
// press pulse and optional auto-repeat per channel. The sample tick is shared.
module btn_debounce_repeat #(
  parameter int NUM_BTN      = 3,
  parameter int TICK_DIV     = 100_000,
  parameter int DEB_LEN      = 8,
  parameter int HOLD_TICKS   = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int REPEAT_EN    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_pulse
);

  localparam int TW = $clog2(TICK_DIV - 1) + 1;
  localparam int HW = $clog2(HOLD_TICKS) + 1;
  localparam int RW = $clog2(REPEAT_TICKS) + 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_PRESS  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [NUM_BTN-1:0] r_sync1;
  logic [NUM_BTN-1:0] r_sync2;
  logic [TW-1:0]      r_tick_cnt;
  logic               w_tick;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_tick_cnt == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
    logic [DEB_LEN-1:0] r_shift;
    logic               r_level;
    logic               r_level_d;
    logic [1:0]         r_state;
    logic [HW-1:0]      r_hold_cnt;
    logic [RW-1:0]      r_rep_cnt;
    logic               r_pulse;
    logic               w_rise;
    logic               w_fall;

    // NOTE: the sample history is reset too, so a button held through reset
    // must be re-qualified from scratch before it can register as a press.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_shift <= '0;
      end else if (w_tick) begin
        r_shift <= {r_shift[DEB_LEN-2:0], r_sync2[gi]};
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_level   <= 1'b0;
        r_level_d <= 1'b0;
      end else begin
        r_level_d <= r_level;
        if (&r_shift) begin
          r_level <= 1'b1;
        end else if (~|r_shift) begin
          r_level <= 1'b0;
        end
      end
    end

    assign w_rise = r_level & ~r_level_d;
    assign w_fall = ~r_level & r_level_d;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_state    <= ST_IDLE;
        r_hold_cnt <= '0;
        r_rep_cnt  <= '0;
        r_pulse    <= 1'b0;
      end else begin
        r_pulse <= 1'b0;
        // Release wins over any hold/repeat expiry landing on the same clock.
        if (w_fall) begin
          r_state    <= ST_IDLE;
          r_hold_cnt <= '0;
          r_rep_cnt  <= '0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_rise) begin
                r_state    <= ST_PRESS;
                r_pulse    <= 1'b1;
                r_hold_cnt <= '0;
              end
            end
            ST_PRESS: begin
              if (w_tick) begin
                if ((REPEAT_EN != 0) && (r_hold_cnt == HW'(HOLD_TICKS - 1))) begin
                  r_state    <= ST_REPEAT;
                  r_pulse    <= 1'b1;
                  r_hold_cnt <= '0;
                  r_rep_cnt  <= '0;
                end else if (r_hold_cnt != HW'(HOLD_TICKS)) begin
                  r_hold_cnt <= r_hold_cnt + 1'b1;
                end
              end
            end
            ST_REPEAT: begin
              if (w_tick) begin
                if (r_rep_cnt == RW'(REPEAT_TICKS - 1)) begin
                  r_pulse   <= 1'b1;
                  r_rep_cnt <= '0;
                end else begin
                  r_rep_cnt <= r_rep_cnt + 1'b1;
                end
              end
            end
            default: begin
              r_state <= ST_IDLE;
            end
          endcase
        end
      end
    end

    assign btn_level[gi] = r_level;
    assign btn_pulse[gi] = r_pulse;
  end

endmodule

// File: tb/tb_btn_debounce_repeat.sv
// Bench for btn_debounce_repeat: tick-arithmetic reference model checked every
// clock, press/hold vector table, reset-while-held sequence, random stimulus.
module tb_btn_debounce_repeat;

  localparam int NUM_BTN      = 3;
  localparam int TICK_DIV     = 10;
  localparam int DEB_LEN      = 4;
  localparam int HOLD_TICKS   = 5;
  localparam int REPEAT_TICKS = 2;
  localparam int LAT          = 2 + DEB_LEN * TICK_DIV + 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NUM_BTN-1:0] btn_in = '0;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_pulse;
  logic [NUM_BTN-1:0] btn_level_nr;
  logic [NUM_BTN-1:0] btn_pulse_nr;

  always #5 clk = ~clk;

  btn_debounce_repeat #(
    .NUM_BTN(NUM_BTN), .TICK_DIV(TICK_DIV), .DEB_LEN(DEB_LEN),
    .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS), .REPEAT_EN(1)
  ) u_dut (
    .clk(clk), .rst(rst_n), .btn_in(btn_in),
    .btn_level(btn_level), .btn_pulse(btn_pulse)
  );

  btn_debounce_repeat #(
    .NUM_BTN(NUM_BTN), .TICK_DIV(TICK_DIV), .DEB_LEN(DEB_LEN),
    .HOLD_TICKS(HOLD_TICKS), .REPEAT_TICKS(REPEAT_TICKS), .REPEAT_EN(0)
  ) u_dut_nr (
    .clk(clk), .rst(rst_n), .btn_in(btn_in),
    .btn_level(btn_level_nr), .btn_pulse(btn_pulse_nr)
  );

  // Reference model: samples are the raw input two clocks late, the level
  // follows runs of equal samples, pulses follow the number of ticks held.
  int                 m_cyc;
  logic [NUM_BTN-1:0] m_d1, m_d2, m_sample;
  int                 m_ones[NUM_BTN];
  int                 m_zeros[NUM_BTN];
  int                 m_ticks[NUM_BTN];
  logic [NUM_BTN-1:0] m_level, m_prev, m_active, m_pulse, m_pulse_nr;
  logic               m_tick, m_new;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc = 0;
      m_d1 = '0;
      m_d2 = '0;
      m_level = '0;
      m_prev = '0;
      m_active = '0;
      m_pulse = '0;
      m_pulse_nr = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        m_ones[i] = 0;
        m_zeros[i] = DEB_LEN;
        m_ticks[i] = 0;
      end
    end else begin
      m_cyc++;
      m_tick = ((m_cyc % TICK_DIV) == 0);
      m_sample = m_d2;
      m_d2 = m_d1;
      m_d1 = btn_in;
      for (int i = 0; i < NUM_BTN; i++) begin
        m_new = (m_ones[i] >= DEB_LEN) ? 1'b1 :
                (m_zeros[i] >= DEB_LEN) ? 1'b0 : m_level[i];
        m_pulse[i] = 1'b0;
        m_pulse_nr[i] = 1'b0;
        if (!m_level[i] && m_prev[i]) begin
          m_active[i] = 1'b0;
        end else if (m_level[i] && !m_prev[i]) begin
          m_active[i] = 1'b1;
          m_ticks[i] = 0;
          m_pulse[i] = 1'b1;
          m_pulse_nr[i] = 1'b1;
        end else if (m_active[i] && m_tick) begin
          m_ticks[i]++;
          m_pulse[i] = (m_ticks[i] >= HOLD_TICKS) &&
                       (((m_ticks[i] - HOLD_TICKS) % REPEAT_TICKS) == 0);
        end
        m_prev[i] = m_level[i];
        m_level[i] = m_new;
        if (m_tick) begin
          if (m_sample[i]) begin
            m_ones[i]++;
            m_zeros[i] = 0;
          end else begin
            m_zeros[i]++;
            m_ones[i] = 0;
          end
        end
      end
    end
  end

  typedef struct {
    logic [NUM_BTN-1:0] pat;
    int                 hold;
    int                 exp_rep;
    int                 exp_nr;
  } vec_t;

  vec_t vecs[7];
  int   total = 0;
  int   bad = 0;
  int   g_cyc = 0;
  int   cnt[NUM_BTN];
  int   cnt_nr[NUM_BTN];
  int   first[NUM_BTN];
  int   p_q[NUM_BTN][$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, g_cyc);
    end
  endtask

  task automatic clear_stats();
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt[i] = 0;
      cnt_nr[i] = 0;
      first[i] = -1;
      p_q[i].delete();
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    g_cyc++;
    check("level", btn_level, m_level);
    check("pulse", btn_pulse, m_pulse);
    check("level_nr", btn_level_nr, m_level);
    check("pulse_nr", btn_pulse_nr, m_pulse_nr);
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn_pulse[i]) begin
        cnt[i]++;
        if (first[i] < 0) first[i] = g_cyc;
        p_q[i].push_back(g_cyc);
      end
      if (btn_pulse_nr[i]) cnt_nr[i]++;
    end
  endtask

  // The hold count starts at the first tick after the press pulse, which
  // itself lands two clocks after a tick: first repeat gap is HOLD*DIV-2.
  task automatic check_gaps(input string tag, input int ch);
    for (int k = 1; k < p_q[ch].size(); k++) begin
      check($sformatf("%s_gap%0d", tag, k), p_q[ch][k] - p_q[ch][k-1],
            (k == 1) ? HOLD_TICKS * TICK_DIV - 2 : REPEAT_TICKS * TICK_DIV);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int start;
    int ref_ch;
    clear_stats();
    start = g_cyc;
    btn_in = v.pat;
    repeat (v.hold) step();
    btn_in = '0;
    for (int s = 1; s <= 80; s++) begin
      step();
      if (s == LAT) check($sformatf("v%0d_release_level", idx), btn_level & v.pat, 0);
    end
    ref_ch = -1;
    for (int i = 0; i < NUM_BTN; i++) begin
      check($sformatf("v%0d_cnt%0d", idx, i), cnt[i], v.pat[i] ? v.exp_rep : 0);
      check($sformatf("v%0d_cnt_nr%0d", idx, i), cnt_nr[i], v.pat[i] ? v.exp_nr : 0);
      if (v.pat[i] && v.exp_rep > 0 && first[i] >= 0) begin
        check($sformatf("v%0d_latency%0d", idx, i), (first[i] - start) <= LAT, 1);
        check_gaps($sformatf("v%0d_ch%0d", idx, i), i);
        if (ref_ch < 0) ref_ch = i;
        else check($sformatf("v%0d_simul%0d", idx, i), first[i], first[ref_ch]);
      end
    end
  endtask

  initial begin
    vecs[0] = '{3'b001,  40, 1, 1};
    vecs[1] = '{3'b010,  15, 0, 0};
    vecs[2] = '{3'b100, 200, 9, 1};
    vecs[3] = '{3'b111,  40, 1, 1};
    vecs[4] = '{3'b001,  30, 0, 0};
    vecs[5] = '{3'b101,  60, 2, 1};
    vecs[6] = '{3'b010,  80, 3, 1};

    clear_stats();
    rst_n = 1'b0;
    btn_in = '0;
    repeat (3) step();
    check("reset_level", btn_level, 0);
    check("reset_pulse", btn_pulse, 0);
    rst_n = 1'b1;
    repeat (20) step();

    for (int v = 0; v < 7; v++) run_vec(vecs[v], v);

    // Reset while auto-repeating, button kept held through and after reset.
    clear_stats();
    btn_in = 3'b100;
    repeat (120) step();
    check("pre_reset_repeating", cnt[2] >= 2, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_level", btn_level, 0);
    check("async_rst_pulse", btn_pulse, 0);
    check("async_rst_level_nr", btn_level_nr, 0);
    repeat (3) step();
    rst_n = 1'b1;
    clear_stats();
    begin
      int start;
      start = g_cyc;
      repeat (130) step();
      check("rst_relatch_latency", first[2] - start, DEB_LEN * TICK_DIV + 2);
      check("rst_pulses_ge3", p_q[2].size() >= 3, 1);
      check_gaps("rst_sched", 2);
    end
    btn_in = '0;
    repeat (80) step();

    for (int r = 0; r < 40; r++) begin
      btn_in = NUM_BTN'($urandom_range(0, 7));
      repeat ($urandom_range(1, 90)) step();
    end
    btn_in = '0;
    repeat (80) step();
    check("final_level", btn_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
